diff_layer_sched: RTL
=====================

Name: diff_layer_sched

Overview:
Layer-level scheduler for the diff core. It holds a small descriptor table, one entry per network layer. On start it sequences the layers one after another: request the buffer loader (weights, bias, fm, guard), issue the layer to the core with a valid/ready handshake, then wait for core_finish. Sits between the host/config interface and the core's core_valid/core_ready/core_finish, core_bit_mode_i and core_is_diff_i inputs.

Parameters:
MAX_LAYERS, 16, descriptor table depth; must be ≥2 (enforced by elaboration assertion).
LW, $clog2(MAX_LAYERS), layer index width.
TIMEOUT, 2**20, cycles allowed in RUN before the watchdog fires; 0 disables the watchdog.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cfg_wr_en  in  1  descriptor write strobe
cfg_wr_addr  in  LW  descriptor index
cfg_wr_data  in  3  descriptor fields: {skip_load, is_diff, bit_mode}
start  in  1  one-cycle start pulse
num_layers  in  LW+1  layers to run; sampled on start
abort  in  1  return to IDLE
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the last layer finishes
err_timeout  out  1  sticky watchdog flag, cleared by start
cur_layer  out  LW  index of the layer in progress
load_req  out  1  loader request, level
load_layer  out  LW  layer index for the loader
load_done  in  1  loader completion pulse
core_valid  out  1  layer issue valid
core_ready  in  1  core idle/accept
core_finish  in  1  core layer-complete pulse
core_bit_mode_o  out  1  bit_mode of the issued layer
core_is_diff_o  out  1  is_diff of the issued layer

Behaviour:
- Reset: state=IDLE. All outputs 0. err_timeout=0. The descriptor table is not reset; its contents are undefined until written.
- Descriptor table writes:
  - Accepted in any state.
  - A write to the entry currently in ISSUE or RUN does not affect the latched core_bit_mode_o / core_is_diff_o.
- States:
  - IDLE:
    - start with num_layers=0 → done pulse next cycle; stay IDLE.
    - start with num_layers>MAX_LAYERS → clamp to MAX_LAYERS.
    - start otherwise → cur_layer=0, clear err_timeout, go to FETCH.
    - start while not IDLE is ignored.
  - FETCH (1 cycle):
    - Read table[cur_layer] into registers; this drives core_bit_mode_o / core_is_diff_o.
    - skip_load=1 → ISSUE. Otherwise assert load_req and set load_layer=cur_layer → LOAD.
  - LOAD:
    - Hold load_req=1 until load_done is sampled.
    - On load_done: load_req=0 next cycle → ISSUE.
    - load_done in any other state is ignored.
  - ISSUE:
    - core_valid=1, held until core_valid&&core_ready.
    - On that handshake edge: core_valid=0 next cycle → RUN.
  - RUN:
    - Wait for core_finish. core_finish outside RUN is ignored.
    - On core_finish:
      - If cur_layer==num_layers−1 → done pulse, go to IDLE.
      - Else cur_layer++, go to FETCH.
    - Layer-to-layer gap: 1 FETCH cycle minimum.
- Watchdog (TIMEOUT≠0):
  - Counter resets on entry to RUN.
  - When the count reaches TIMEOUT: set err_timeout, go to IDLE, no done pulse.
- abort:
  - Any state → IDLE next cycle.
  - load_req and core_valid drop immediately on that edge.
  - No done pulse.
  - abort has priority over every other event in the same cycle.
- Simultaneous events:
  - core_finish and the watchdog expiring in the same cycle → finish wins.
  - start and abort in IDLE → abort wins; stay IDLE.
- core_bit_mode_o / core_is_diff_o stay stable from FETCH through the end of RUN.

Optional Feature:
SCHED_PERF_CNT_EN:
- When defined, adds outputs perf_load_cycles[31:0] and perf_run_cycles[31:0].
- Both clear on start.
- perf_load_cycles counts cycles spent in LOAD; perf_run_cycles counts cycles spent in ISSUE plus RUN.
- Both saturate at 2^32−1 and hold their value in IDLE.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Write 3 descriptors {0,0,1},{1,1,0},{0,1,1}; start with num_layers=3; loader replies after 5 cycles; core_ready=1; core_finish after 10 cycles → one load_req each for layers 0 and 2 only; core_bit_mode_o sequence 1,0,1; core_is_diff_o sequence 0,1,1; done exactly once; busy falls in the same cycle done pulses.
- Hold core_ready=0 for 7 cycles in ISSUE → core_valid stays high for 8 cycles; RUN is entered only after the handshake.
- Set TIMEOUT=32 and never assert core_finish → err_timeout=1 after 32 RUN cycles, state IDLE, no done; the next start clears err_timeout.
- Assert abort in LOAD with load_req high → load_req=0 and busy=0 next cycle; a late load_done has no effect; a following start runs normally from layer 0.
- start with num_layers=0 → done pulse 1 cycle later; load_req and core_valid never assert. start with num_layers=MAX_LAYERS+1 → exactly MAX_LAYERS layers run.
- With SCHED_PERF_CNT_EN, run 2 layers with 5-cycle load and 10-cycle core (core_ready=1) → perf_load_cycles=10, perf_run_cycles=2×(1+10)=22.

Source files
------------

// File: rtl/diff_layer_sched.sv
// Layer sequencer for the diff core: per layer FETCH -> (LOAD) -> ISSUE -> RUN.
// Latency: one FETCH cycle between layers; done pulses one cycle after the last core_finish.
// Backpressure: ISSUE holds core_valid until core_ready; LOAD holds load_req until load_done.
// Optional SCHED_PERF_CNT_EN adds perf_load_cycles / perf_run_cycles counters.
module diff_layer_sched #(
    parameter int MAX_LAYERS = 16,
    parameter int LW         = $clog2(MAX_LAYERS),
    parameter int TIMEOUT    = 2**20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_wr_en,
    input  logic [LW-1:0] cfg_wr_addr,
    input  logic [2:0]    cfg_wr_data,
    input  logic          start,
    input  logic [LW:0]   num_layers,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic [LW-1:0] cur_layer,
    output logic          load_req,
    output logic [LW-1:0] load_layer,
    input  logic          load_done,
    output logic          core_valid,
    input  logic          core_ready,
    input  logic          core_finish,
    output logic          core_bit_mode_o,
    output logic          core_is_diff_o
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]   perf_load_cycles,
    output logic [31:0]   perf_run_cycles
`endif
);

    if (MAX_LAYERS < 2) begin : g_bad_max_layers
        $error("diff_layer_sched: MAX_LAYERS must be >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_RUN} state_t;

    localparam logic [LW:0] MAX_L  = MAX_LAYERS[LW:0];
    localparam logic [31:0] WD_END = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [2:0]    table_q [MAX_LAYERS];
    logic [2:0]    desc;
    logic [LW:0]   num_q;
    logic [LW-1:0] cur_q;
    logic [LW-1:0] load_layer_q;
    logic          bit_mode_q, is_diff_q;
    logic          done_q, err_q;
    logic [31:0]   wd_cnt_q;
    logic          last_layer;
    logic          wd_fire;

    assign desc       = table_q[cur_q];
    assign last_layer = ({1'b0, cur_q} == (num_q - 1'b1));
    // finish is checked first in RUN, so the watchdog only fires without it
    assign wd_fire    = (TIMEOUT != 0) && (wd_cnt_q == WD_END);

    // descriptor table: written in any state, intentionally not reset
    always_ff @(posedge clk) begin
        if (cfg_wr_en) table_q[cfg_wr_addr] <= cfg_wr_data;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next-state logic; abort overrides everything
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start && num_layers != '0) state_d = S_FETCH;
                S_FETCH: state_d = desc[2] ? S_ISSUE : S_LOAD;
                S_LOAD:  if (load_done) state_d = S_ISSUE;
                S_ISSUE: if (core_ready) state_d = S_RUN;
                S_RUN: begin
                    if (core_finish)  state_d = last_layer ? S_IDLE : S_FETCH;
                    else if (wd_fire) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // state-decoded outputs
    always_comb begin
        busy       = (state_q != S_IDLE);
        load_req   = (state_q == S_LOAD);
        core_valid = (state_q == S_ISSUE);
    end

    // layer index, latched descriptor, done/error flags and watchdog count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q        <= '0;
            cur_q        <= '0;
            load_layer_q <= '0;
            bit_mode_q   <= 1'b0;
            is_diff_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wd_cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (!abort) begin
                case (state_q)
                    S_IDLE: if (start) begin
                        err_q <= 1'b0;
                        if (num_layers == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            cur_q <= '0;
                            num_q <= (num_layers > MAX_L) ? MAX_L : num_layers;
                        end
                    end
                    S_FETCH: begin
                        bit_mode_q <= desc[0];
                        is_diff_q  <= desc[1];
                        if (!desc[2]) load_layer_q <= cur_q;
                    end
                    S_ISSUE: if (core_ready) wd_cnt_q <= '0;
                    S_RUN: begin
                        if (core_finish) begin
                            if (last_layer) done_q <= 1'b1;
                            else            cur_q  <= cur_q + 1'b1;
                        end else if (wd_fire) begin
                            err_q <= 1'b1;
                        end else begin
                            wd_cnt_q <= wd_cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign done            = done_q;
    assign err_timeout     = err_q;
    assign cur_layer       = cur_q;
    assign load_layer      = load_layer_q;
    assign core_bit_mode_o = bit_mode_q;
    assign core_is_diff_o  = is_diff_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_load_q, perf_run_q;

    // saturating LOAD and ISSUE+RUN cycle counters, cleared by an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_load_q <= '0;
            perf_run_q  <= '0;
        end else if (state_q == S_IDLE && start && !abort) begin
            perf_load_q <= '0;
            perf_run_q  <= '0;
        end else begin
            if (state_q == S_LOAD && perf_load_q != '1)
                perf_load_q <= perf_load_q + 1'b1;
            if ((state_q == S_ISSUE || state_q == S_RUN) && perf_run_q != '1)
                perf_run_q <= perf_run_q + 1'b1;
        end
    end

    assign perf_load_cycles = perf_load_q;
    assign perf_run_cycles  = perf_run_q;
`else
    // performance counters not built
`endif

endmodule
